fpmul_arbiter: RTL and testbench
================================

// Module: fpmul_arbiter
// PURPOSE
// - Shares one single-precision FP multiplier (mul_start/mul_serv/mul_done/mul_busy handshake) among NREQ requesters.
// - Round-robin grant; operands are latched and mul_start is issued; the result is captured and returned to the winner.
// - A watchdog covers a multiplier that never completes.
// - Sits between the issue logic of the FP units and the shared multiplier.
// PARAMETERS
// - NREQ     4   number of requesters (2..8)
// - TIMEOUT  15  max WAIT cycles for mul_done before abort (>=2)
// PORTS
// - clk           in   1         rising-edge clock
// - n_rst         in   1         reset, synchronous, active-low
// - req           in   NREQ      request; held high with stable operands until served
// - req_op1       in   NREQ*32   operand A, requester i at [32*i+:32]
// - req_op2       in   NREQ*32   operand B, same packing
// - gnt           out  NREQ      one-hot current owner; high ISSUE..RESP
// - result        out  32        product for owner; valid while result_valid
// - result_valid  out  NREQ      one-hot; result ready for requester i
// - result_taken  in   NREQ      requester i consumes result
// - result_err    out  1         qualifies result: 1 = timeout abort
// - arb_busy      out  1         high whenever state != IDLE
// - mul_start     out  1         1-cycle start pulse to multiplier
// - mul_serv      out  1         1-cycle pulse: result consumed, multiplier may clear done
// - mul_op1       out  32        registered operand A to multiplier
// - mul_op2       out  32        registered operand B to multiplier
// - mul_result    in   32        multiplier product
// - mul_done      in   1         multiplier result valid
// - mul_busy      in   1         multiplier computing
// BEHAVIOUR
// Reset
// - While n_rst=0 at a clk edge: state=IDLE, rr_ptr=0.
// - All outputs 0: gnt, result_valid, result, result_err, mul_start, mul_serv, mul_op1, mul_op2, arb_busy.
// - Reset mid-operation aborts silently. No mul_serv is issued; the multiplier is reset by the same n_rst.
// FSM
// - IDLE: if |req, pick the first set bit searching from rr_ptr upward (mod NREQ).
//   - Latch the owner index, its op1/op2 into mul_op1/mul_op2, and gnt.
//   - Go to ISSUE.
// - ISSUE: mul_start=1 for exactly this cycle; clear wdog counter; go to WAIT.
// - WAIT: count cycles.
//   - If mul_done && !mul_busy: result<=mul_result, result_err<=0, go to RESP.
//   - Else if count==TIMEOUT-1: result<=32'h7FC0_0000 (qNaN), result_err<=1, go to RESP.
//   - mul_done is not sampled in the ISSUE cycle, so a stale done is ignored.
// - RESP: result_valid[owner]=1.
//   - On result_taken[owner], or on req[owner]==0 (withdrawn, result discarded): assert mul_serv=1 for one cycle.
//   - In that same cycle: rr_ptr<=(owner+1)%NREQ, gnt<=0, return to IDLE.
// Latency and throughput
// - req seen in IDLE at cycle 0 -> mul_start in cycle 1 -> earliest result_valid in cycle 3.
// - Minimum 4 cycles per operation; no back-to-back overlap.
// Boundary conditions
// - Simultaneous requests are served in rotating order. The last-served requester has the lowest priority next.
// - A new req arriving during ISSUE/WAIT/RESP waits; it is not lost.
// - result_taken for a non-owner is ignored. Operand changes after grant are ignored because the operands are latched.
// - NREQ not a power of two: pointer wrap uses explicit compare, not truncation.
// Width rules
// - Watchdog counter is $clog2(TIMEOUT+1) bits and saturates.
// - Owner index is $clog2(NREQ) bits (minimum 1).
// STRUCTURE
// - Package fpmul_pkg holds:
//   - FP32_W=32
//   - FP32_QNAN=32'h7FC0_0000
//   - typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} fpmul_arb_state_t
// - Sub-module rr_picker #(N): combinational round-robin priority encoder.
//   - Inputs: req, ptr. Outputs: any, idx, onehot.
// - All other logic is one always_ff for state/registers plus one always_comb for next-state and outputs.
// TESTING
// - Single req[0], op1=3FC00000, op2=40000000, ideal mul (done 1 cycle after start):
//   - mul_start in cycle 1; result_valid=0001 in cycle 3; result=40400000; mul_serv 1 cycle after taken.
// - req=1111 held continuously, every result taken immediately: grant order 0,1,2,3,0.
//   - Each gnt lasts ISSUE..RESP; exactly one mul_start per grant.
// - req[2] alone, mul_done never asserts:
//   - After TIMEOUT WAIT cycles, result=7FC00000 and result_err=1; after taken, mul_serv pulses and state returns to IDLE.
// - req[1] with result_taken held low for 10 cycles:
//   - result_valid[1] and result stay stable; no mul_serv. Then drop req[1] -> discard, mul_serv pulse, IDLE.
// - n_rst=0 during WAIT with req=0011:
//   - Next edge: all outputs 0, no mul_serv. After release, req[0] is granted first (rr_ptr=0).
// - op1=40000000, op2=40000000 from req[3], while req[0] rises during WAIT:
//   - result=40800000 to requester 3; requester 0 is granted next.

Source files
------------

// File: rtl/fpmul_pkg.sv
// Shared types and constants for the FP multiplier arbiter slice.
package fpmul_pkg;

    localparam int              FP32_W    = 32;
    localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} fpmul_arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first set request at or above ptr, wrapping mod N.
module rr_picker #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    int cand;

    // Scan from the farthest candidate back to ptr so the nearest set bit wins;
    // the wrap is an explicit compare so non-power-of-two N works.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        cand   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= N) cand = cand - N;
            if (req[cand[IW-1:0]]) begin
                any = 1'b1;
                idx = cand[IW-1:0];
            end
        end
        if (any) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/fpmul_arbiter.sv
// Round-robin arbiter sharing one FP32 multiplier among NREQ requesters, with a completion watchdog.
module fpmul_arbiter
    import fpmul_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*FP32_W-1:0] req_op1,
    input  logic [NREQ*FP32_W-1:0] req_op2,
    output logic [NREQ-1:0]        gnt,
    output logic [FP32_W-1:0]      result,
    output logic [NREQ-1:0]        result_valid,
    input  logic [NREQ-1:0]        result_taken,
    output logic                   result_err,
    output logic                   arb_busy,
    output logic                   mul_start,
    output logic                   mul_serv,
    output logic [FP32_W-1:0]      mul_op1,
    output logic [FP32_W-1:0]      mul_op2,
    input  logic [FP32_W-1:0]      mul_result,
    input  logic                   mul_done,
    input  logic                   mul_busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    fpmul_arb_state_t state, state_nxt;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    rr_ptr;
    logic [CW-1:0]    wdog;

    logic             pick_any;
    logic [IW-1:0]    pick_idx;
    logic [NREQ-1:0]  pick_onehot;
    logic             owner_release;
    logic             mul_ok;
    logic             wdog_expired;

    rr_picker #(.N(NREQ)) u_picker (
        .req    (req),
        .ptr    (rr_ptr),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_comb begin
        mul_ok        = mul_done && !mul_busy;
        wdog_expired  = (wdog == CW'(TIMEOUT - 1));
        owner_release = result_taken[owner] || !req[owner];
        state_nxt     = state;
        mul_start     = 1'b0;
        result_valid  = '0;
        arb_busy      = (state != IDLE);
        case (state)
            IDLE:    if (pick_any) state_nxt = ISSUE;
            ISSUE: begin
                mul_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT:    if (mul_ok || wdog_expired) state_nxt = RESP;
            RESP: begin
                result_valid[owner] = 1'b1;
                if (owner_release) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // mul_serv is registered: it pulses in the cycle after the result is
    // released, so a done left over from the previous job is never sampled.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            wdog       <= '0;
            gnt        <= '0;
            result     <= '0;
            result_err <= 1'b0;
            mul_op1    <= '0;
            mul_op2    <= '0;
            mul_serv   <= 1'b0;
        end else begin
            state    <= state_nxt;
            mul_serv <= 1'b0;
            case (state)
                IDLE: if (pick_any) begin
                    owner   <= pick_idx;
                    gnt     <= pick_onehot;
                    mul_op1 <= req_op1[FP32_W*pick_idx +: FP32_W];
                    mul_op2 <= req_op2[FP32_W*pick_idx +: FP32_W];
                end
                ISSUE: wdog <= '0;
                WAIT: begin
                    if (mul_ok) begin
                        result     <= mul_result;
                        result_err <= 1'b0;
                    end else if (wdog_expired) begin
                        result     <= FP32_QNAN;
                        result_err <= 1'b1;
                    end else if (wdog != {CW{1'b1}}) begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESP: if (owner_release) begin
                    mul_serv <= 1'b1;
                    gnt      <= '0;
                    rr_ptr   <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Randomized bench for fpmul_arbiter: transaction-level reference model plus directed scenarios.
module tb_fpmul_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 15;

    logic               clk = 0;
    logic               n_rst = 0;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*32-1:0] req_op1 = '0;
    logic [NREQ*32-1:0] req_op2 = '0;
    logic [NREQ-1:0]    gnt;
    logic [31:0]        result;
    logic [NREQ-1:0]    result_valid;
    logic [NREQ-1:0]    result_taken = '0;
    logic               result_err;
    logic               arb_busy;
    logic               mul_start;
    logic               mul_serv;
    logic [31:0]        mul_op1;
    logic [31:0]        mul_op2;
    logic [31:0]        mul_result = '0;
    logic               mul_done = 0;
    logic               mul_busy = 0;

    fpmul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .n_rst(n_rst), .req(req), .req_op1(req_op1), .req_op2(req_op2),
        .gnt(gnt), .result(result), .result_valid(result_valid), .result_taken(result_taken),
        .result_err(result_err), .arb_busy(arb_busy), .mul_start(mul_start), .mul_serv(mul_serv),
        .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_result(mul_result),
        .mul_done(mul_done), .mul_busy(mul_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Plain FP32 product of two normal numbers, mantissa truncated.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] m;
        int          e;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    // ---------------- multiplier environment ----------------
    logic            st_s = 0, sv_s = 0, rs_s = 0;
    logic [NREQ-1:0] served_s = '0;
    int              remain = 0;
    int              mul_lat = 1;     // 0 = never completes
    bit              mul_rand = 0;

    always @(negedge clk) begin
        st_s     = mul_start;
        sv_s     = mul_serv;
        rs_s     = n_rst;
        served_s = result_valid & (result_taken | ~req);
    end

    always @(posedge clk) begin
        #1;
        if (!rs_s) begin
            mul_done = 0; mul_busy = 0; remain = 0;
        end else begin
            if (sv_s) begin
                mul_done = 0; mul_busy = 0; remain = 0;
            end
            if (st_s) begin
                if (mul_rand) remain = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 5));
                else          remain = (mul_lat == 0) ? -1 : mul_lat;
                mul_done = 0; mul_busy = 1;
            end
            if (remain > 0) begin
                remain--;
                if (remain == 0) begin
                    mul_done = 1; mul_busy = 0;
                    mul_result = fp_mul(mul_op1, mul_op2);
                end else begin
                    mul_busy = 1;
                    mul_done = mul_rand && ($urandom_range(0, 3) == 0);
                end
            end
            if (!mul_done || mul_busy) mul_result = $urandom;
        end
    end

    // ---------------- reference model ----------------
    // One transaction at a time: who owns the multiplier, how long since the
    // grant, and whether the answer is already being offered.
    int          m_own = -1, m_since = 0, m_ptr = 0;
    bit          m_ans = 0, m_serv = 0, m_err = 0;
    logic [31:0] m_res = '0, m_op1 = '0, m_op2 = '0;
    int          c;

    always @(posedge clk) begin
        if (!n_rst) begin
            m_own = -1; m_ptr = 0; m_ans = 0; m_serv = 0; m_err = 0;
            m_res = '0; m_op1 = '0; m_op2 = '0; m_since = 0;
        end else begin
            m_serv = 0;
            if (m_own < 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    c = (m_ptr + k) % NREQ;
                    if (req[c] && m_own < 0) begin
                        m_own = c; m_since = 0; m_ans = 0;
                        m_op1 = req_op1[32*c +: 32];
                        m_op2 = req_op2[32*c +: 32];
                    end
                end
            end else if (!m_ans) begin
                if (m_since >= 1 && mul_done && !mul_busy) begin
                    m_ans = 1; m_res = mul_result; m_err = 0;
                end else if (m_since == TIMEOUT) begin
                    m_ans = 1; m_res = 32'h7FC0_0000; m_err = 1;
                end
                m_since++;
            end else if (result_taken[m_own] || !req[m_own]) begin
                m_serv = 1; m_ptr = (m_own + 1) % NREQ; m_own = -1; m_ans = 0;
            end
        end
    end

    logic [NREQ-1:0] eg, erv;
    always @(negedge clk) begin
        if (chk_en) begin
            eg = '0; erv = '0;
            if (m_own >= 0) begin
                eg[m_own] = 1'b1;
                if (m_ans) erv[m_own] = 1'b1;
            end
            chk("gnt", gnt, eg);
            chk("result_valid", result_valid, erv);
            chk("mul_start", mul_start, (m_own >= 0 && !m_ans && m_since == 0));
            chk("mul_serv", mul_serv, m_serv);
            chk("arb_busy", arb_busy, (m_own >= 0));
            chk("result", result, m_res);
            chk("result_err", result_err, m_err);
            chk("mul_op1", mul_op1, m_op1);
            chk("mul_op2", mul_op2, m_op2);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rv(input int i, input int max, output int cyc);
        cyc = -1;
        for (int k = 1; k <= max; k++) begin
            step();
            if (result_valid[i]) begin
                cyc = k;
                break;
            end
        end
        if (cyc < 0) chk("wait_result_valid", result_valid[i], 1'b1);
    endtask

    task automatic take(input int i);
        result_taken[i] = 1;
        step();
        result_taken[i] = 0;
        req[i] = 0;
    endtask

    int          t_start, t_rv, cyc, ng;
    logic [3:0]  gseq [5];
    logic [3:0]  prev_g;
    logic [31:0] a, b;
    bit          serv_seen;

    initial begin
        // reset with garbage on the request side
        req = 4'b1011;
        repeat (3) step();
        chk_en = 1;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", arb_busy, 0);
        chk("rst_result", result, 0);
        chk("rst_op1", mul_op1, 0);
        req = '0;
        n_rst = 1;
        step();

        chk("model_fp_1p5x2", fp_mul(32'h3FC0_0000, 32'h4000_0000), 32'h4040_0000);
        chk("model_fp_2x2", fp_mul(32'h4000_0000, 32'h4000_0000), 32'h4080_0000);

        // single request, ideal multiplier
        mul_lat = 1;
        req_op1[31:0] = 32'h3FC0_0000;
        req_op2[31:0] = 32'h4000_0000;
        req[0] = 1;
        t_start = -1; t_rv = -1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (mul_start && t_start < 0) t_start = k;
            if (result_valid[0]) begin
                t_rv = k;
                break;
            end
        end
        chk("lat_start", t_start, 1);
        chk("lat_result_valid", t_rv, 3);
        chk("ideal_result", result, 32'h4040_0000);
        chk("ideal_rv", result_valid, 4'b0001);
        take(0);
        chk("ideal_serv", mul_serv, 1);

        // watchdog abort
        mul_lat = 0;
        req[2] = 1;
        wait_rv(2, 40, cyc);
        chk("timeout_latency", cyc, TIMEOUT + 2);
        chk("timeout_result", result, 32'h7FC0_0000);
        chk("timeout_err", result_err, 1);
        take(2);
        chk("timeout_serv", mul_serv, 1);
        chk("timeout_idle", arb_busy, 0);

        // rotating order with every requester asking continuously
        n_rst = 0; step(); n_rst = 1;
        mul_lat = 1;
        req = 4'b1111;
        ng = 0; prev_g = '0;
        for (int k = 0; k < 60 && ng < 5; k++) begin
            step();
            if (gnt != 0 && prev_g == 0) begin
                gseq[ng] = gnt;
                ng++;
            end
            prev_g = gnt;
            result_taken = result_valid;
        end
        result_taken = '0;
        req = 4'b0001;
        chk("rr_count", ng, 5);
        chk("rr_g0", gseq[0], 4'b0001);
        chk("rr_g1", gseq[1], 4'b0010);
        chk("rr_g2", gseq[2], 4'b0100);
        chk("rr_g3", gseq[3], 4'b1000);
        chk("rr_g4", gseq[4], 4'b0001);
        wait_rv(0, 20, cyc);
        take(0);

        // reset in the middle of WAIT
        mul_lat = 0;
        req = 4'b0011;
        repeat (4) step();
        n_rst = 0;
        step();
        chk("midrst_gnt", gnt, 0);
        chk("midrst_busy", arb_busy, 0);
        chk("midrst_serv", mul_serv, 0);
        chk("midrst_op1", mul_op1, 0);
        n_rst = 1;
        mul_lat = 1;
        step();
        chk("midrst_first_gnt", gnt, 4'b0001);
        req[1] = 0;
        wait_rv(0, 20, cyc);
        take(0);

        // newcomer during WAIT is served next
        mul_lat = 3;
        req_op1[127:96] = 32'h4000_0000;
        req_op2[127:96] = 32'h4000_0000;
        req[3] = 1;
        step(); step();
        req_op1[31:0] = $urandom;
        req_op2[31:0] = $urandom;
        req[0] = 1;
        wait_rv(3, 20, cyc);
        chk("late_result", result, 32'h4080_0000);
        take(3);
        for (int k = 0; k < 10 && gnt == 0; k++) step();
        chk("late_next_gnt", gnt, 4'b0001);
        wait_rv(0, 20, cyc);
        take(0);

        // result held while not taken, then withdrawn
        mul_lat = 2;
        a = 32'h4120_0000; b = 32'h3F40_0000;
        req_op1[63:32] = a;
        req_op2[63:32] = b;
        req[1] = 1;
        wait_rv(1, 20, cyc);
        serv_seen = 0;
        repeat (10) begin
            step();
            serv_seen = serv_seen | mul_serv;
        end
        chk("hold_rv", result_valid, 4'b0010);
        chk("hold_result", result, fp_mul(a, b));
        chk("hold_no_serv", serv_seen, 0);
        req[1] = 0;
        step();
        chk("withdraw_serv", mul_serv, 1);
        chk("withdraw_idle", arb_busy, 0);

        // randomized traffic
        mul_rand = 1;
        repeat (4000) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (served_s[i]) begin
                    result_taken[i] = 0;
                    req[i] = 1'($urandom_range(0, 1));
                    req_op1[32*i +: 32] = $urandom;
                    req_op2[32*i +: 32] = $urandom;
                end else if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1;
                        req_op1[32*i +: 32] = $urandom;
                        req_op2[32*i +: 32] = $urandom;
                    end
                    result_taken[i] = ($urandom_range(0, 7) == 0);
                end else if (result_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) begin
                        req[i] = 0;
                        result_taken[i] = 0;
                    end else begin
                        result_taken[i] = ($urandom_range(0, 2) == 0);
                    end
                end else if (gnt[i]) begin
                    if ($urandom_range(0, 3) == 0) req_op1[32*i +: 32] = $urandom;
                    result_taken[i] = 1'($urandom_range(0, 1));
                end else begin
                    result_taken[i] = ($urandom_range(0, 5) == 0);
                end
            end
        end
        req = '0;
        result_taken = '0;
        repeat (30) step();
        chk("drain_idle", arb_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit actual=running required=finished");
        $fatal(1, "time limit");
    end

endmodule
